// File: rtl/usb_token_serializer.sv
// USB token packet serializer: PID, 11-bit ADDR/ENDP payload and CRC5, one bit per clock.
// The CRC is produced by an external calculator and replayed by an external inverse shifter.
module usb_token_serializer #(
  parameter int PID_W   = 8,
  parameter int DATA_W  = 11,
  parameter int CRC_W   = 5,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PID_W-1:0]  in_pid,
  input  logic [DATA_W-1:0] in_data,
  output logic              crc_clr,
  output logic              crc_bit,
  input  logic [CRC_W-1:0]  crc_rem,
  output logic              inv_load,
  output logic [CRC_W-1:0]  inv_in,
  input  logic              inv_bit,
  output logic              tx_bit,
  output logic              tx_valid,
  output logic              tx_sop,
  output logic              tx_eop
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  localparam int MAX_CNT = max2(max2(PID_W, DATA_W), max2(CRC_W, GAP_CYC));
  localparam int CNT_W   = $clog2(MAX_CNT + 1);

  localparam logic [CNT_W-1:0] PID_LAST  = CNT_W'(PID_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] CRC_LAST  = CNT_W'(CRC_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PID,
    S_DATA,
    S_CRC,
    S_GAP
  } state_t;

  state_t            state, state_d;
  logic [CNT_W-1:0]  cnt, cnt_d;
  logic              accept;
  logic [PID_W-1:0]  pid_sr;
  logic [DATA_W-1:0] data_sr;

  // The shifter is loaded with the calculator's look-ahead remainder, which
  // already includes the last payload bit on the final DATA cycle.
  assign inv_in = crc_rem;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, regardless of process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  // NOTE: the payload shift registers carry no reset; they are always loaded
  // on accept before any state reads them, so a reset would only cost area.
  always_ff @(posedge clk) begin
    if (accept) begin
      pid_sr  <= in_pid;
      data_sr <= in_data;
    end else begin
      if (state == S_PID)  pid_sr  <= pid_sr >> 1;
      if (state == S_DATA) data_sr <= data_sr >> 1;
    end
  end

  always_comb begin
    // NOTE: every signal written here is given a default first, so no branch
    // can leave one unassigned and infer a latch.
    state_d  = state;
    cnt_d    = cnt + 1'b1;
    accept   = 1'b0;
    in_ready = 1'b0;
    crc_clr  = 1'b1;
    crc_bit  = 1'b0;
    inv_load = 1'b0;
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    tx_sop   = 1'b0;
    tx_eop   = 1'b0;

    unique case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        cnt_d    = '0;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = S_PID;
        end
      end

      S_PID: begin
        tx_bit   = pid_sr[0];
        tx_valid = 1'b1;
        tx_sop   = (cnt == '0);
        if (cnt == PID_LAST) begin
          state_d = S_DATA;
          cnt_d   = '0;
        end
      end

      S_DATA: begin
        crc_clr  = 1'b0;
        crc_bit  = data_sr[0];
        tx_bit   = data_sr[0];
        tx_valid = 1'b1;
        if (cnt == DATA_LAST) begin
          inv_load = 1'b1;
          state_d  = S_CRC;
          cnt_d    = '0;
        end
      end

      S_CRC: begin
        tx_bit   = inv_bit;
        tx_valid = 1'b1;
        tx_eop   = (cnt == CRC_LAST);
        if (cnt == CRC_LAST) begin
          state_d = (GAP_CYC == 0) ? S_IDLE : S_GAP;
          cnt_d   = '0;
        end
      end

      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule
